mem_stage: RTL

Memory-access pipeline stage between EX and WB. It accepts one instruction per handshake from EX and waits for the `data_ok` response of any data request EX issued. It buffers response data when WB back-pressures, and aligns and extends load data. It forwards results to ID and drops stale responses belonging to flushed instructions.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data responses, buffers them under WB back-pressure,
// aligns/extends load data, forwards to ID and drops stale responses after a flush.
// Optional feature: define MEM_LOAD_FWD_EN to forward load data to ID once it arrives.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] ex_pc,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_res_from_mem,
    input  logic [1:0]  ex_ld_size,
    input  logic        ex_ld_unsigned,
    input  logic        ex_mem_req,
    input  logic        ex_excep_en,
    input  logic        ex_ertn,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [1:0]  mem_to_ex_bus,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_rf_wdata,
    output logic        mem_rf_we,
    output logic [4:0]  mem_rf_waddr,
    output logic        mem_excep_en,
    output logic        mem_ertn,
    output logic        mem_fwd_we,
    output logic [4:0]  mem_fwd_waddr,
    output logic [31:0] mem_fwd_wdata,
    output logic        mem_fwd_stall
);

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } ld_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [1:0]  ld_size;
        logic        ld_unsigned;
        logic        excep_en;
        logic        ertn;
    } payload_t;

    logic        mem_valid_q,  mem_valid_d;
    logic        wait_data_q,  wait_data_d;
    logic        buf_valid_q,  buf_valid_d;
    logic [31:0] rdata_buf_q,  rdata_buf_d;
    logic [1:0]  cancel_cnt_q, cancel_cnt_d;
    payload_t    payload_q,    payload_d;

    logic        data_ok_acc;
    logic        ready_go;
    logic        accept;
    logic        leave;
    logic        cancel_inc;
    logic        cancel_dec;
    logic [31:0] eff_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic        rf_we_gated;

    // A response is ours only once every stale one owed to flushed loads has drained.
    assign data_ok_acc     = data_sram_data_ok & (cancel_cnt_q == 2'd0);
    assign ready_go        = ~wait_data_q | data_ok_acc;
    assign mem_allowin     = (~mem_valid_q | (ready_go & wb_allowin)) & (cancel_cnt_q != 2'd3);
    assign mem_to_wb_valid = mem_valid_q & ready_go;
    assign accept          = ex_to_mem_valid & mem_allowin;
    assign leave           = mem_to_wb_valid & wb_allowin;
    assign cancel_inc      = flush & mem_valid_q & wait_data_q & ~data_ok_acc;
    assign cancel_dec      = data_sram_data_ok & (cancel_cnt_q != 2'd0);

    // NOTE: every variable gets its hold value first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        mem_valid_d  = mem_valid_q;
        wait_data_d  = wait_data_q;
        buf_valid_d  = buf_valid_q;
        rdata_buf_d  = rdata_buf_q;
        cancel_cnt_d = cancel_cnt_q;
        payload_d    = payload_q;

        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_to_mem_valid;
        end

        if (flush) begin
            wait_data_d = 1'b0;
        end else if (accept) begin
            wait_data_d = ex_mem_req;
        end else if (data_ok_acc) begin
            wait_data_d = 1'b0;
        end

        if (data_ok_acc) begin
            rdata_buf_d = data_sram_rdata;
        end
        // Leaving or flushing wins over capture so a later instruction never sees old data.
        if (flush || leave) begin
            buf_valid_d = 1'b0;
        end else if (data_ok_acc) begin
            buf_valid_d = 1'b1;
        end

        if (cancel_inc && !cancel_dec) begin
            cancel_cnt_d = cancel_cnt_q + 2'd1;
        end else if (cancel_dec && !cancel_inc) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
        end

        if (accept) begin
            payload_d.pc           = ex_pc;
            payload_d.rf_we        = ex_rf_we;
            payload_d.rf_waddr     = ex_rf_waddr;
            payload_d.alu_result   = ex_alu_result;
            payload_d.res_from_mem = ex_res_from_mem;
            payload_d.ld_size      = ex_ld_size;
            payload_d.ld_unsigned  = ex_ld_unsigned;
            payload_d.excep_en     = ex_excep_en;
            payload_d.ertn         = ex_ertn;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            wait_data_q  <= 1'b0;
            buf_valid_q  <= 1'b0;
            // NOTE: the data buffer is reset as well so the load path is fully defined straight out of reset.
            rdata_buf_q  <= 32'd0;
            cancel_cnt_q <= 2'd0;
            payload_q    <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            wait_data_q  <= wait_data_d;
            buf_valid_q  <= buf_valid_d;
            rdata_buf_q  <= rdata_buf_d;
            cancel_cnt_q <= cancel_cnt_d;
            payload_q    <= payload_d;
        end
    end

    assign eff_rdata = buf_valid_q ? rdata_buf_q : data_sram_rdata;

    always_comb begin
        ld_byte = eff_rdata[7:0];
        case (payload_q.alu_result[1:0])
            2'd0: ld_byte = eff_rdata[7:0];
            2'd1: ld_byte = eff_rdata[15:8];
            2'd2: ld_byte = eff_rdata[23:16];
            2'd3: ld_byte = eff_rdata[31:24];
            default: ld_byte = eff_rdata[7:0];
        endcase
        ld_half = payload_q.alu_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];

        load_data = eff_rdata;
        case (ld_size_e'(payload_q.ld_size))
            SIZE_BYTE: load_data = {{24{~payload_q.ld_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = {{16{~payload_q.ld_unsigned & ld_half[15]}}, ld_half};
            default:   load_data = eff_rdata;
        endcase
    end

    assign rf_we_gated   = payload_q.rf_we & mem_valid_q & ~payload_q.excep_en;

    assign mem_to_ex_bus = {mem_valid_q & payload_q.excep_en, mem_valid_q & payload_q.ertn};
    assign mem_pc        = payload_q.pc;
    assign mem_rf_wdata  = payload_q.res_from_mem ? load_data : payload_q.alu_result;
    assign mem_rf_we     = rf_we_gated;
    assign mem_rf_waddr  = payload_q.rf_waddr;
    assign mem_excep_en  = payload_q.excep_en;
    assign mem_ertn      = payload_q.ertn;

    assign mem_fwd_waddr = payload_q.rf_waddr;
    assign mem_fwd_wdata = mem_rf_wdata;

`ifdef MEM_LOAD_FWD_EN
    // Load data becomes forwardable as soon as the accepted response is visible.
    assign mem_fwd_we    = mem_valid_q & rf_we_gated;
    assign mem_fwd_stall = mem_valid_q & payload_q.res_from_mem & ~ready_go;
`else
    // Loads never bypass from MEM; ID picks them up from WB instead.
    assign mem_fwd_we    = mem_valid_q & rf_we_gated & ~payload_q.res_from_mem;
    assign mem_fwd_stall = mem_valid_q & payload_q.res_from_mem;
`endif

endmodule
